lfsr_gen: RTL and testbench

Parametrised maximal-length LFSR generator, successor to the fixed 3-bit LFSR. It generates pseudo-random sequences for any width from 3 to 32 bits, with a selectable Fibonacci or Galois structure. It adds run-time seed loading, a step enable, all-zero lockup recovery and a period-wrap indicator. It feeds test-pattern generators, scramblers and BIST sequencers in the design.

---
 rtl/lfsr_gen.sv | 161 ++++++++++++++++
 tb/tb_lfsr_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// Maximal-length LFSR for widths 3..32 with a Fibonacci or Galois structure.
// Supports run-time seed load, step enable, zero-state recovery and period-wrap indication.
module lfsr_gen #(
  parameter int unsigned    N      = 8,
  parameter bit             GALOIS = 1'b0,
  parameter logic [N-1:0]   SEED   = {{(N-1){1'b0}}, 1'b1}
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         load,
  input  logic [1:N]   seed,
  output logic [1:N]   Q,
  output logic         bit_out,
  output logic [N-1:0] count,
  output logic         wrap,
  output logic         lockup
);

  if ((N < 3) || (N > 32)) begin : g_bad_width
    $error("lfsr_gen: N must be in 3..32");
  end
  if (SEED == {N{1'b0}}) begin : g_bad_seed
    $error("lfsr_gen: SEED must be non-zero");
  end

  // Bit t of the result marks tap position t; bit 0 is a don't-care sink for unused slots.
  function automatic logic [32:0] pos4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    logic [32:0] m;
    m = (33'd1 << a) | (33'd1 << b) | (33'd1 << c) | (33'd1 << d);
    m[0] = 1'b0;
    return m;
  endfunction

  function automatic logic [32:0] tap_set(input int unsigned n);
    logic [32:0] m;
    case (n)
      3:       m = pos4(3, 2, 0, 0);
      4:       m = pos4(4, 3, 0, 0);
      5:       m = pos4(5, 3, 0, 0);
      6:       m = pos4(6, 5, 0, 0);
      7:       m = pos4(7, 6, 0, 0);
      8:       m = pos4(8, 6, 5, 4);
      9:       m = pos4(9, 5, 0, 0);
      10:      m = pos4(10, 7, 0, 0);
      11:      m = pos4(11, 9, 0, 0);
      12:      m = pos4(12, 6, 4, 1);
      13:      m = pos4(13, 4, 3, 1);
      14:      m = pos4(14, 5, 3, 1);
      15:      m = pos4(15, 14, 0, 0);
      16:      m = pos4(16, 15, 13, 4);
      17:      m = pos4(17, 14, 0, 0);
      18:      m = pos4(18, 11, 0, 0);
      19:      m = pos4(19, 6, 2, 1);
      20:      m = pos4(20, 17, 0, 0);
      21:      m = pos4(21, 19, 0, 0);
      22:      m = pos4(22, 21, 0, 0);
      23:      m = pos4(23, 18, 0, 0);
      24:      m = pos4(24, 23, 22, 17);
      25:      m = pos4(25, 22, 0, 0);
      26:      m = pos4(26, 6, 2, 1);
      27:      m = pos4(27, 5, 2, 1);
      28:      m = pos4(28, 25, 0, 0);
      29:      m = pos4(29, 27, 0, 0);
      30:      m = pos4(30, 6, 4, 1);
      31:      m = pos4(31, 28, 0, 0);
      32:      m = pos4(32, 22, 2, 1);
      default: m = 33'd0;
    endcase
    return m;
  endfunction

  localparam logic [32:0]  TAPS  = tap_set(N);
  localparam logic [1:N]   ZERO  = {N{1'b0}};
  localparam logic [N-1:0] C_ONE = {{(N-1){1'b0}}, 1'b1};

  logic [1:N]   q_q, q_d, start_q, start_d, step_v;
  logic [N-1:0] count_q, count_d;
  logic         wrap_q, wrap_d, lockup_q, lockup_d;
  logic         fb;

  // One LFSR step from the current state in the selected structure.
  always_comb begin
    fb     = 1'b0;
    step_v = q_q;
    for (int k = 1; k <= N; k++) begin
      fb = fb ^ (q_q[k] & TAPS[k]);
    end
    if (GALOIS) begin
      step_v[1] = q_q[N];
      for (int k = 2; k <= N; k++) begin
        step_v[k] = q_q[k-1] ^ (q_q[N] & TAPS[k-1]);
      end
    end else begin
      step_v[1] = fb;
      for (int k = 2; k <= N; k++) begin
        step_v[k] = q_q[k-1];
      end
    end
  end

  // Next-state selection: load, then zero-state recovery, then step, else hold.
  always_comb begin
    q_d      = q_q;
    start_d  = start_q;
    count_d  = count_q;
    wrap_d   = 1'b0;
    lockup_d = 1'b0;
    if (load) begin
      count_d = {N{1'b0}};
      if (seed != ZERO) begin
        q_d     = seed;
        start_d = seed;
      end else begin
        q_d      = SEED;
        start_d  = SEED;
        lockup_d = 1'b1;
      end
    end else if (q_q == ZERO) begin
      q_d      = SEED;
      start_d  = SEED;
      count_d  = {N{1'b0}};
      lockup_d = 1'b1;
    end else if (en) begin
      q_d = step_v;
      if (step_v == start_q) begin
        wrap_d  = 1'b1;
        count_d = {N{1'b0}};
      end else begin
        count_d = count_q + C_ONE;
      end
    end else begin
      q_d = q_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_q      <= SEED;
      start_q  <= SEED;
      count_q  <= {N{1'b0}};
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      start_q  <= start_d;
      count_q  <= count_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

  assign Q       = q_q;
  assign bit_out = q_q[N];
  assign count   = count_q;
  assign wrap    = wrap_q;
  assign lockup  = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: a 3-bit Fibonacci and an 8-bit Galois instance share control
// inputs; an integer-arithmetic reference model predicts every cycle.
module tb_lfsr_gen;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0, en = 1'b0, load = 1'b0;
  logic [2:0] seed_a = 3'd0, q_a, cnt_a;
  logic [7:0] seed_b = 8'd0, q_b, cnt_b;
  logic       bo_a, bo_b, wrap_a, wrap_b, lock_a, lock_b;
  int         total = 0, bad = 0;

  always #5 clk = ~clk;

  lfsr_gen #(.N(3), .GALOIS(1'b0), .SEED(3'd1)) u_a (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .seed(seed_a),
    .Q(q_a), .bit_out(bo_a), .count(cnt_a), .wrap(wrap_a), .lockup(lock_a));

  lfsr_gen #(.N(8), .GALOIS(1'b1), .SEED(8'h5A)) u_b (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .seed(seed_b),
    .Q(q_b), .bit_out(bo_b), .count(cnt_b), .wrap(wrap_b), .lockup(lock_b));

  typedef struct {
    int unsigned qa, ca, qb, cb;
    bit          wa, la, wb, lb;
  } exp_t;
  exp_t sbq[$];

  // Reference model: state held as an integer whose MSB is Q[1]; tmask bit t marks tap t.
  int unsigned nn[2] = '{3, 8};
  bit          gl[2] = '{1'b0, 1'b1};
  int unsigned sdv[2] = '{1, 32'h5A};
  int unsigned tm[2] = '{(1 << 3) | (1 << 2), (1 << 8) | (1 << 6) | (1 << 5) | (1 << 4)};
  int unsigned mq[2], ms[2], mc[2];
  bit          mw[2], ml[2];

  function automatic int unsigned lfsr_next(int unsigned n, bit gal, int unsigned tmask,
                                            int unsigned s);
    int unsigned nx, fb;
    if (!gal) begin
      fb = 0;
      for (int t = 1; t <= int'(n); t++)
        if (tmask[t]) fb = fb ^ ((s >> (n - t)) & 1);
      nx = (fb << (n - 1)) | (s >> 1);
    end else begin
      nx = s >> 1;
      if (s[0]) begin
        nx = nx | (1 << (n - 1));
        for (int t = 1; t < int'(n); t++)
          if (tmask[t]) nx = nx ^ (1 << (n - 1 - t));
      end
    end
    return nx;
  endfunction

  task automatic model(int i, bit r, bit l, bit e, int unsigned sd, bit fz);
    mw[i] = 1'b0;
    ml[i] = 1'b0;
    if (!r) begin
      mq[i] = sdv[i]; ms[i] = sdv[i]; mc[i] = 0;
    end else if (l) begin
      mc[i] = 0;
      if (sd != 0) begin mq[i] = sd; ms[i] = sd; end
      else begin mq[i] = sdv[i]; ms[i] = sdv[i]; ml[i] = 1'b1; end
    end else if (fz || mq[i] == 0) begin
      mq[i] = sdv[i]; ms[i] = sdv[i]; mc[i] = 0; ml[i] = 1'b1;
    end else if (e) begin
      mq[i] = lfsr_next(nn[i], gl[i], tm[i], mq[i]);
      if (mq[i] == ms[i]) begin mw[i] = 1'b1; mc[i] = 0; end
      else mc[i] = mc[i] + 1;
    end
  endtask

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // One clock of stimulus; the predicted post-edge outputs go to the scoreboard.
  task automatic cyc(bit r, bit l, bit e, logic [2:0] sa, logic [7:0] sb, bit fz);
    exp_t x;
    @(negedge clk);
    reset_n = r; load = l; en = e; seed_a = sa; seed_b = sb;
    if (fz) begin
      force u_a.q_q = 3'b000;
      #1;
      release u_a.q_q;
    end
    model(0, r, l, e, int'(sa), fz);
    model(1, r, l, e, int'(sb), 1'b0);
    x.qa = mq[0]; x.ca = mc[0]; x.wa = mw[0]; x.la = ml[0];
    x.qb = mq[1]; x.cb = mc[1]; x.wb = mw[1]; x.lb = ml[1];
    sbq.push_back(x);
    @(posedge clk);
  endtask

  // Monitor: every edge the DUTs present a fresh result, compared against the queue head.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        chk("a_q", q_a, x.qa);         chk("a_count", cnt_a, x.ca);
        chk("a_wrap", wrap_a, x.wa);   chk("a_lockup", lock_a, x.la);
        chk("a_bit_out", bo_a, x.qa & 1);
        chk("b_q", q_b, x.qb);         chk("b_count", cnt_b, x.cb);
        chk("b_wrap", wrap_b, x.wb);   chk("b_lockup", lock_b, x.lb);
        chk("b_bit_out", bo_b, x.qb & 1);
      end
    end
  end

  initial begin
    int unsigned seq_a[7] = '{4, 2, 5, 6, 7, 3, 1};
    int          wrap_step, n_wraps;
    bit          r, l, e, fz;
    logic [2:0]  sa;
    logic [7:0]  sb;

    cyc(1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 3'd0, 8'd0, 1'b0);
    #2;
    chk("rst_q_a", q_a, 1);
    chk("rst_q_b", q_b, 8'h5A);

    // Known 3-bit Fibonacci sequence; wrap only on the 7th step.
    wrap_step = 0; n_wraps = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 3'd0, 8'd0, 1'b0);
      #2;
      chk("a_seq", q_a, seq_a[i]);
      chk("a_seq_wrap", wrap_a, (i == 6) ? 1 : 0);
      chk("a_seq_count", cnt_a, (i == 6) ? 0 : i + 1);
    end

    // 8-bit Galois instance keeps stepping: exactly one wrap, at step 255.
    for (int s = 8; s <= 260; s++) begin
      cyc(1'b1, 1'b0, 1'b1, 3'd0, 8'd0, 1'b0);
      #2;
      if (wrap_b) begin
        n_wraps++;
        if (wrap_step == 0) wrap_step = s;
      end
    end
    chk("b_period", wrap_step, 255);
    chk("b_wrap_count", n_wraps, 1);

    // Load of a zero seed recovers to SEED with a lockup pulse.
    cyc(1'b1, 1'b1, 1'b1, 3'd0, 8'd0, 1'b0);
    #2;
    chk("ld0_q_a", q_a, 1);
    chk("ld0_lock_a", lock_a, 1);
    cyc(1'b1, 1'b0, 1'b1, 3'd0, 8'd0, 1'b0);
    #2;
    chk("ld0_lock_clear", lock_a, 0);

    // load beats en; seven steps return to the loaded value.
    cyc(1'b1, 1'b1, 1'b1, 3'b101, 8'h33, 1'b0);
    #2;
    chk("ld101_q", q_a, 5);
    chk("ld101_count", cnt_a, 0);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 3'd0, 8'd0, 1'b0);
    end
    #2;
    chk("ld101_wrap_q", q_a, 5);
    chk("ld101_wrap", wrap_a, 1);

    // Corrupt the state to zero: recovery takes priority over the step.
    cyc(1'b1, 1'b0, 1'b1, 3'd0, 8'd0, 1'b1);
    #2;
    chk("fz_q", q_a, 1);
    chk("fz_lock", lock_a, 1);
    cyc(1'b1, 1'b0, 1'b1, 3'd0, 8'd0, 1'b0);
    #2;
    chk("fz_resume_q", q_a, 4);
    chk("fz_lock_clear", lock_a, 0);

    // Random control traffic with occasional resets, loads and upsets.
    for (int i = 0; i < 2000; i++) begin
      r  = ($urandom_range(99) >= 2);
      l  = ($urandom_range(99) < 6);
      e  = ($urandom_range(99) < 70);
      sa = 3'($urandom_range(7));
      sb = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom);
      fz = r && !l && ($urandom_range(99) < 3);
      cyc(r, l, e, sa, sb, fz);
    end

    @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
